or_gate_rr_arb: RTL and testbench
=================================

Name: or_gate_rr_arb

Overview:
- Shares one registered OR-combine stage (out = w | r) between `num` requesters.
- Each requester offers a (w, r) word pair with a valid/ready handshake.
- A round-robin arbiter grants one requester per accepted cycle into a single-entry output register. The output register drives a valid/ready consumer and is tagged with the winning requester's id.
- Sits between per-channel producers and a single shared downstream sink.

Parameters:
- num, 4, number of requesters; legal range 2..16, power of two not required.
- bits, 32, data width of w, r and out_data.
- cnt_bits, 16, width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  num  per-requester valid; bit k belongs to requester k.
- in_w  input  num*bits  requester k's w word at [k*bits +: bits].
- in_r  input  num*bits  requester k's r word at [k*bits +: bits].
- in_ready  output  num  one-hot or zero; requester k's word is taken this cycle.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  bits  registered in_w[k] | in_r[k] of the granted requester.
- out_id  output  $clog2(num)  index k of the requester that produced out_data.
- xfer_cnt  output  cnt_bits  number of accepted input transfers, wrapping.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - out_valid=0, out_data=0, out_id=0, xfer_cnt=0, round-robin pointer ptr=0.
  - in_ready=0 as long as reset is held.
  - Reset mid-transfer discards any held result; no partial state survives.
- Load enable: load = !out_valid || out_ready. This gives full throughput: one result per cycle with no bubble under continuous out_ready=1.
- Grant selection (combinational):
  - Search in_valid starting at index ptr, upward with wrap from num-1 to 0.
  - The first set bit wins; grant is one-hot, or zero if no valid.
- in_ready = grant & {num{load}}. in_ready never depends on in_valid of other requesters beyond the grant search, and never combinationally depends on out_valid going low in the same cycle.
- Input transfer on requester k: in_valid[k] && in_ready[k]. On the next clk edge:
  - out_data <= in_w[k] | in_r[k], out_id <= k, out_valid <= 1.
  - ptr <= (k == num-1) ? 0 : k+1.
  - xfer_cnt <= xfer_cnt + 1, modulo 2^cnt_bits, wrapping silently.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Output consumed, with no new input transfer in the same cycle: out_valid <= 0. out_data and out_id keep their last values.
- Backpressure (out_valid=1, out_ready=0):
  - load=0, all in_ready=0.
  - out_data and out_id stay stable; ptr and xfer_cnt are unchanged.
- Simultaneous consume and load in one cycle: the new result replaces the old one; out_valid stays 1.
- No in_valid set: ptr unchanged; out_valid follows the consume rule.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,…,num-1,0,… Each requester waits at most num-1 grants.
- Requesters must hold in_valid and data stable until in_ready. The block does not check this.

Decomposition:
- Package or_gate_arb_pkg:
  - function clog2_min1(n), returning at least 1.
  - localparam-style typedef id_t sized from num.
  - Default constant for cnt_bits.
- Sub-module or_gate_rr_pick (combinational):
  - Inputs: req[num], ptr.
  - Outputs: grant one-hot, gnt_id, any.
  - Implemented as a double-width rotate plus priority encode.
- The OR datapath is inline in or_gate_rr_arb as one bits-wide mux followed by an OR.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then idle with in_valid=0 → out_valid=0, out_data=0, out_id=0, xfer_cnt=0, in_ready=0.
- Single transfer: in_valid=4'b0100, w[2]=0x0000_00F0, r[2]=0x0000_000F, out_ready=1 → in_ready=4'b0100. Next cycle: out_valid=1, out_data=0x0000_00FF, out_id=2, xfer_cnt=1. The following cycle: out_valid=0.
- Round robin: in_valid=4'b1111 held, out_ready=1, 8 cycles → out_id sequence 0,1,2,3,0,1,2,3 and xfer_cnt=8.
- Backpressure: result id=1 held, out_ready=0 for 5 cycles with in_valid=4'b1111 → in_ready=0 throughout; out_data/out_id stable. On out_ready=1, next grant is id=2 in the same cycle.
- Wrap and skip: num=4, ptr=3, in_valid=4'b0010 → grant id=1, ptr becomes 2. Separately, xfer_cnt preset to 0xFFFF plus one transfer → 0x0000.
- Async reset mid-operation: assert rst_n=0 between clock edges while out_valid=1 and out_ready=0 → out_valid drops immediately. After release, first grant with in_valid=4'b1000 is id=3 (search from ptr=0).

Source files
------------

// File: rtl/or_gate_arb_pkg.sv
// Shared definitions for the round-robin OR-combine arbiter.
//   clog2_min1 : index width helper, never returns less than 1 bit
//   DEF_*      : default parameter values for the arbiter top
//   id_t       : requester index type for the default requester count
package or_gate_arb_pkg;

    localparam int DEF_NUM      = 4;
    localparam int DEF_BITS     = 32;
    localparam int DEF_CNT_BITS = 16;

    // A single requester still needs a 1-bit index field.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [clog2_min1(DEF_NUM)-1:0] id_t;

endpackage

// File: rtl/or_gate_rr_pick.sv
// Combinational round-robin picker.
//   req    : per-requester request bits
//   ptr    : index where the search starts (highest priority)
//   grant  : one-hot grant, zero when no request is set
//   gnt_id : index of the granted requester (0 when none)
//   any    : at least one request is set
module or_gate_rr_pick
    import or_gate_arb_pkg::*;
#(
    parameter int num  = DEF_NUM,
    parameter int id_w = clog2_min1(num)
) (
    input  logic [num-1:0]  req,
    input  logic [id_w-1:0] ptr,
    output logic [num-1:0]  grant,
    output logic [id_w-1:0] gnt_id,
    output logic            any
);

    logic [num-1:0] rot;
    int             sel;

    // Duplicating req and shifting by ptr puts the requester at ptr in bit 0
    // and the wrapped-around ones above it, so a plain lowest-bit priority
    // encode implements the circular search. The scan runs downward so the
    // last hit is the lowest set bit.
    always_comb begin
        rot = num'({req, req} >> ptr);
        any = 1'b0;
        sel = 0;
        for (int j = num - 1; j >= 0; j--) begin
            if (rot[j]) begin
                any = 1'b1;
                sel = int'(ptr) + j;
            end
        end
        if (sel >= num) begin
            sel = sel - num;
        end
        gnt_id = id_w'(sel);
        grant  = any ? (num'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/or_gate_rr_arb.sv
// Round-robin arbiter sharing one registered OR-combine stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-requester valid
//   in_w, in_r : per-requester word pair, requester k at [k*bits +: bits]
//   in_ready   : one-hot (or zero) acceptance strobe back to requesters
//   out_valid  : output register holds a result
//   out_ready  : downstream consumer accepts the result
//   out_data   : in_w[k] | in_r[k] of the granted requester, registered
//   out_id     : index k that produced out_data
//   xfer_cnt   : wrapping count of accepted input transfers
module or_gate_rr_arb
    import or_gate_arb_pkg::*;
#(
    parameter int num      = DEF_NUM,
    parameter int bits     = DEF_BITS,
    parameter int cnt_bits = DEF_CNT_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [num-1:0]             in_valid,
    input  logic [num*bits-1:0]        in_w,
    input  logic [num*bits-1:0]        in_r,
    output logic [num-1:0]             in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [bits-1:0]            out_data,
    output logic [clog2_min1(num)-1:0] out_id,
    output logic [cnt_bits-1:0]        xfer_cnt
);

    localparam int id_w = clog2_min1(num);

    logic [id_w-1:0] ptr;
    logic [num-1:0]  grant;
    logic [id_w-1:0] gnt_id;
    logic            any;
    logic            load;
    logic            xfer;
    logic [bits-1:0] sel_w;
    logic [bits-1:0] sel_r;

    or_gate_rr_pick #(
        .num  (num),
        .id_w (id_w)
    ) u_pick (
        .req    (in_valid),
        .ptr    (ptr),
        .grant  (grant),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // rst_n is folded in so no requester sees ready while reset is held,
    // even though the cleared output register would otherwise allow a load.
    always_comb begin
        load     = rst_n && (!out_valid || out_ready);
        in_ready = grant & {num{load}};
        xfer     = any && load;
        sel_w    = in_w[int'(gnt_id)*bits +: bits];
        sel_r    = in_r[int'(gnt_id)*bits +: bits];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            xfer_cnt  <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_w | sel_r;
            out_id    <= gnt_id;
            xfer_cnt  <= xfer_cnt + cnt_bits'(1);
            ptr       <= (gnt_id == id_w'(num - 1)) ? '0 : gnt_id + id_w'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_or_gate_rr_arb.sv
// Self-checking bench for or_gate_rr_arb: directed scenarios plus random
// traffic, compared against a behavioural model of the arbiter.
module tb_or_gate_rr_arb;

    localparam int NUM  = 4;
    localparam int BITS = 32;
    // Narrow counter so the wrap boundary is reached in ~1k transfers.
    localparam int CB   = 10;
    localparam int MAXC = (1 << CB) - 1;

    logic                 clk;
    logic                 rst_n;
    logic [NUM-1:0]       in_valid;
    logic [NUM*BITS-1:0]  in_w;
    logic [NUM*BITS-1:0]  in_r;
    logic [NUM-1:0]       in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [BITS-1:0]      out_data;
    logic [1:0]           out_id;
    logic [CB-1:0]        xfer_cnt;

    or_gate_rr_arb #(
        .num      (NUM),
        .bits     (BITS),
        .cnt_bits (CB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_w      (in_w),
        .in_r      (in_r),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [BITS-1:0] wv [NUM];
    logic [BITS-1:0] rv [NUM];

    // Behavioural model state
    int              mPtr;
    int              mId;
    int              mCnt;
    logic            mValid;
    logic [BITS-1:0] mData;

    logic [NUM-1:0]  lastReady;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM-1:0] v, input logic ordy);
        in_valid  = v;
        out_ready = ordy;
        for (int k = 0; k < NUM; k++) begin
            in_w[k*BITS +: BITS] = wv[k];
            in_r[k*BITS +: BITS] = rv[k];
        end
    endtask

    // First valid requester searching circularly from p, or -1.
    function automatic int modelPick(input logic [NUM-1:0] v, input int p);
        for (int i = 0; i < NUM; i++) begin
            if (v[(p + i) % NUM]) return (p + i) % NUM;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mPtr   = 0;
        mId    = 0;
        mCnt   = 0;
        mValid = 1'b0;
        mData  = '0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(mValid));
        checkOutput({tag, ".out_data"},  64'(out_data),  64'(mData));
        checkOutput({tag, ".out_id"},    64'(out_id),    64'(mId));
        checkOutput({tag, ".xfer_cnt"},  64'(xfer_cnt),  64'(mCnt));
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs.
    task automatic stepCycle(input string tag, input logic [NUM-1:0] v, input logic ordy);
        int k;
        logic [NUM-1:0] expReady;
        logic canLoad;
        @(negedge clk);
        applyStimulus(v, ordy);
        #1;
        canLoad  = !mValid || ordy;
        k        = modelPick(v, mPtr);
        expReady = (canLoad && k >= 0) ? NUM'(1) << k : '0;
        lastReady = in_ready;
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(expReady));
        if (canLoad && k >= 0) begin
            mData  = wv[k] | rv[k];
            mId    = k;
            mValid = 1'b1;
            mPtr   = (k + 1) % NUM;
            mCnt   = (mCnt + 1) % (1 << CB);
        end else if (ordy) begin
            mValid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkState(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        modelReset();
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("rst.in_ready", 64'(in_ready), 64'd0);
        end
        checkState("rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            wv[k] = '0;
            rv[k] = '0;
        end
        applyStimulus(4'b0000, 1'b0);
        modelReset();

        // Reset and idle
        doReset();
        stepCycle("idle", 4'b0000, 1'b1);
        checkOutput("idle.in_ready", 64'(lastReady), 64'd0);

        // Single transfer from requester 2
        wv[2] = 32'h0000_00F0;
        rv[2] = 32'h0000_000F;
        stepCycle("single", 4'b0100, 1'b1);
        checkOutput("single.ready", 64'(lastReady), 64'b0100);
        checkOutput("single.data", 64'(out_data), 64'h0000_00FF);
        checkOutput("single.id", 64'(out_id), 64'd2);
        checkOutput("single.cnt", 64'(xfer_cnt), 64'd1);
        stepCycle("single_drain", 4'b0000, 1'b1);
        checkOutput("single.drained", 64'(out_valid), 64'd0);

        // Round robin from a fresh pointer
        doReset();
        for (int k = 0; k < NUM; k++) begin
            wv[k] = 32'h1000_0000 * (k + 1);
            rv[k] = 32'h0000_0001 << k;
        end
        for (int i = 0; i < 8; i++) begin
            stepCycle("rr", 4'b1111, 1'b1);
            checkOutput("rr.id_seq", 64'(out_id), 64'(i % NUM));
        end
        checkOutput("rr.cnt", 64'(xfer_cnt), 64'd8);

        // Backpressure holding a result from requester 1
        stepCycle("bp_load", 4'b0010, 1'b1);
        checkOutput("bp.load_id", 64'(out_id), 64'd1);
        for (int i = 0; i < 5; i++) begin
            stepCycle("bp_hold", 4'b1111, 1'b0);
            checkOutput("bp.ready0", 64'(lastReady), 64'd0);
            checkOutput("bp.id_stable", 64'(out_id), 64'd1);
            checkOutput("bp.data_stable", 64'(out_data), 64'(wv[1] | rv[1]));
        end
        stepCycle("bp_release", 4'b1111, 1'b1);
        checkOutput("bp.release_ready", 64'(lastReady), 64'b0100);

        // Pointer now 3; only requester 1 valid wraps around to it
        stepCycle("wrap_skip", 4'b0010, 1'b1);
        checkOutput("wrap_skip.id", 64'(out_id), 64'd1);
        stepCycle("wrap_skip_ptr", 4'b1100, 1'b1);
        checkOutput("wrap_skip.next", 64'(out_id), 64'd2);

        // Asynchronous reset between edges while a result is held
        stepCycle("ar_load", 4'b0001, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("ar.valid_drop", 64'(out_valid), 64'd0);
        checkState("ar");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle("ar_after", 4'b1000, 1'b1);
        checkOutput("ar.first_ready", 64'(lastReady), 64'b1000);
        checkOutput("ar.first_id", 64'(out_id), 64'd3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM; k++) begin
                wv[k] = $urandom;
                rv[k] = $urandom;
            end
            stepCycle("rand", NUM'($urandom), ($urandom_range(0, 9) < 7));
        end

        // Counter wrap: stream until the count sits at its maximum, then once more
        for (int i = 0; i < 2 * (MAXC + 1) && mCnt != MAXC; i++) begin
            stepCycle("cnt_run", 4'b1111, 1'b1);
        end
        checkOutput("cnt.at_max", 64'(xfer_cnt), 64'(MAXC));
        stepCycle("cnt_wrap", 4'b1111, 1'b1);
        checkOutput("cnt.wrapped", 64'(xfer_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
